// File: rtl/pwm_capture.sv
// pwm_capture: decodes an external PWM waveform into period, high time and duty cycle.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   en_i       capture enable (0: FSM idle, divide aborted, outputs hold)
//   clr_i      synchronous clear, highest priority: aborts everything, zeroes outputs
//   pwm_i      asynchronous PWM input (2-flop synchronized internally)
//   high_o     high cycles of last measured period
//   period_o   rising-edge to rising-edge cycles of last measured period
//   duty_o     round(high*100/period), 0..100
//   valid_o    1-cycle pulse: high_o/period_o/duty_o/stuck_o just updated
//   stuck_o    input constant for 2^W-1 cycles; cleared by next valid measurement
//   overrun_o  1-cycle pulse: completed period dropped because the divider was busy
module pwm_capture #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         pwm_i,
  output logic [W-1:0] high_o,
  output logic [W-1:0] period_o,
  output logic [6:0]   duty_o,
  output logic         valid_o,
  output logic         stuck_o,
  output logic         overrun_o
);

  localparam int NW = W + 7;          // dividend width: hi*100 + per/2 < 2^(W+7)
  localparam int CW = $clog2(NW);
  localparam logic [W-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0] DIV_LAST = CW'(NW - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;

  state_e         state_q, state_d;
  logic           sync_meta_q, sync_meta_d;
  logic           sync_q, sync_d;
  logic           sync_dly_q, sync_dly_d;
  logic [W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [W-1:0]   per_cnt_q, per_cnt_d;
  logic           busy_q, busy_d;
  logic [CW-1:0]  div_cnt_q, div_cnt_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [NW-1:0]  quo_q, quo_d;
  logic [W-1:0]   div_hi_q, div_hi_d;
  logic [W-1:0]   div_per_q, div_per_d;
  logic [W-1:0]   high_q, high_d;
  logic [W-1:0]   period_q, period_d;
  logic [6:0]     duty_q, duty_d;
  logic           valid_q, valid_d;
  logic           stuck_q, stuck_d;
  logic           overrun_q, overrun_d;

  logic           rise;
  logic [W-1:0]   per_inc;
  logic [W:0]     rem_shift;
  logic [W:0]     rem_sub;
  logic           quo_bit;
  logic [NW-1:0]  quo_next;
  logic [W-1:0]   rem_next;
  logic [NW-1:0]  dividend;
  logic           timeout;

  assign rise    = sync_q & ~sync_dly_q;
  assign per_inc = per_cnt_q + W'(1);

  // One restoring-division step: the dividend is shifted out of quo_q MSB-first
  // while quotient bits are shifted in at the bottom.
  assign rem_shift = {rem_q, quo_q[NW-1]};
  assign rem_sub   = rem_shift - {1'b0, div_per_q};
  assign quo_bit   = ~rem_sub[W];     // no borrow: remainder >= divisor
  assign quo_next  = {quo_q[NW-2:0], quo_bit};
  assign rem_next  = quo_bit ? rem_sub[W-1:0] : rem_shift[W-1:0];

  // Adding per/2 before the truncating divide gives round-half-up.
  assign dividend = NW'(hi_cnt_q) * NW'(100) + NW'(per_cnt_q >> 1);

  always_comb begin
    state_d     = state_q;
    sync_meta_d = pwm_i;
    sync_d      = sync_meta_q;
    sync_dly_d  = sync_q;
    hi_cnt_d    = hi_cnt_q;
    per_cnt_d   = per_cnt_q;
    busy_d      = busy_q;
    div_cnt_d   = div_cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_hi_d    = div_hi_q;
    div_per_d   = div_per_q;
    high_d      = high_q;
    period_d    = period_q;
    duty_d      = duty_q;
    valid_d     = 1'b0;
    stuck_d     = stuck_q;
    overrun_d   = 1'b0;
    timeout     = 1'b0;

    if (!en_i) begin
      state_d   = S_IDLE;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      busy_d    = 1'b0;
      div_cnt_d = '0;
    end else begin
      if (busy_q) begin
        rem_d     = rem_next;
        quo_d     = quo_next;
        div_cnt_d = div_cnt_q + CW'(1);
        if (div_cnt_q == DIV_LAST) begin
          busy_d   = 1'b0;
          high_d   = div_hi_q;
          period_d = div_per_q;
          duty_d   = quo_next[6:0];   // quotient <= 100
          stuck_d  = 1'b0;
          valid_d  = 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          // per_cnt doubles as the no-rise watchdog while idle
          if (rise) begin
            state_d   = S_HIGH;
            hi_cnt_d  = W'(1);
            per_cnt_d = W'(1);
          end else begin
            per_cnt_d = per_inc;
            if (per_inc == CNT_MAX) timeout = 1'b1;
          end
        end
        S_HIGH: begin
          per_cnt_d = per_inc;
          if (sync_q) hi_cnt_d = hi_cnt_q + W'(1);
          else        state_d  = S_LOW;
          if (per_inc == CNT_MAX) timeout = 1'b1;
        end
        S_LOW: begin
          if (rise) begin
            if (!busy_q) begin
              busy_d    = 1'b1;
              div_cnt_d = '0;
              rem_d     = '0;
              quo_d     = dividend;
              div_hi_d  = hi_cnt_q;
              div_per_d = per_cnt_q;
            end else begin
              overrun_d = 1'b1;
            end
            state_d   = S_HIGH;
            hi_cnt_d  = W'(1);
            per_cnt_d = W'(1);
          end else begin
            per_cnt_d = per_inc;
            if (per_inc == CNT_MAX) timeout = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Timeout overrides any divide completing in the same cycle.
      if (timeout) begin
        state_d   = S_IDLE;
        hi_cnt_d  = '0;
        per_cnt_d = '0;
        busy_d    = 1'b0;
        div_cnt_d = '0;
        // A repeat idle timeout while already stuck stays silent.
        if (!(state_q == S_IDLE && stuck_q)) begin
          valid_d  = 1'b1;
          stuck_d  = 1'b1;
          high_d   = '0;
          period_d = '0;
          duty_d   = sync_q ? 7'd100 : 7'd0;
        end
      end
    end

    if (clr_i) begin
      state_d   = S_IDLE;
      hi_cnt_d  = '0;
      per_cnt_d = '0;
      busy_d    = 1'b0;
      div_cnt_d = '0;
      rem_d     = '0;
      quo_d     = '0;
      div_hi_d  = '0;
      div_per_d = '0;
      high_d    = '0;
      period_d  = '0;
      duty_d    = '0;
      valid_d   = 1'b0;
      stuck_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      sync_dly_q  <= 1'b0;
      hi_cnt_q    <= '0;
      per_cnt_q   <= '0;
      busy_q      <= 1'b0;
      div_cnt_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_hi_q    <= '0;
      div_per_q   <= '0;
      high_q      <= '0;
      period_q    <= '0;
      duty_q      <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_meta_q <= sync_meta_d;
      sync_q      <= sync_d;
      sync_dly_q  <= sync_dly_d;
      hi_cnt_q    <= hi_cnt_d;
      per_cnt_q   <= per_cnt_d;
      busy_q      <= busy_d;
      div_cnt_q   <= div_cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_hi_q    <= div_hi_d;
      div_per_q   <= div_per_d;
      high_q      <= high_d;
      period_q    <= period_d;
      duty_q      <= duty_d;
      valid_q     <= valid_d;
      stuck_q     <= stuck_d;
      overrun_q   <= overrun_d;
    end
  end

  assign high_o    = high_q;
  assign period_o  = period_q;
  assign duty_o    = duty_q;
  assign valid_o   = valid_q;
  assign stuck_o   = stuck_q;
  assign overrun_o = overrun_q;

endmodule
